mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 if_req  in  1  fetch requests an instruction word.
REQ-005 if_addr  in  32  fetch address; requester holds it stable while if_stall=1.
REQ-006 if_rdata  out  32  fetched word; valid when if_valid=1.
REQ-007 if_valid  out  1  one-cycle pulse: if_rdata is valid.
REQ-008 if_stall  out  1  fetch must hold its request.
REQ-009 ex_readmem  in  1  execute/memory stage requests a load.
REQ-010 ex_writemem  in  1  execute/memory stage requests a store.
REQ-011 ex_addr  in  32  data address; held stable while ex_stall=1.
REQ-012 ex_wdata  in  32  store data; held stable while ex_stall=1.
REQ-013 ex_rdata  out  32  load result; valid when ex_done=1.
REQ-014 ex_done  out  1  one-cycle pulse: data access complete.
REQ-015 ex_stall  out  1  data requester must hold its request.
REQ-016 mem_addr  out  32  shared memory port address (registered).
REQ-017 mem_wdata  out  32  shared memory port write data (registered).
REQ-018 mem_read  out  1  port read strobe (registered).
REQ-019 mem_write  out  1  port write strobe (registered).
REQ-020 mem_rdata  in  32  port read data, sampled when mem_ready=1.
REQ-021 mem_ready  in  1  port completes the current access this cycle.
REQ-022 stall_cycles  out  16  saturating count of cycles with if_stall=1.

Function
REQ-023 FSM states SHALL be IDLE, FETCH and DATA; exactly one access is outstanding on the port at any time.
REQ-024 IDLE: an ex request (readmem|writemem) goes to DATA; otherwise if_req goes to FETCH; otherwise stay in IDLE.
REQ-025 On each grant edge the block SHALL latch addr, wdata and op into the mem_* registers.
REQ-026 The mem_* registers SHALL hold those values unchanged until the edge on which mem_ready=1 is sampled.
REQ-027 A store SHALL never pulse mem_read.
REQ-028 Fairness: if a DATA completion occurs while if_req=1, the next grant SHALL be FETCH even if an ex request is pending.
REQ-029 Apart from REQ-028, data SHALL have priority.
REQ-030 Completion in FETCH (mem_ready=1): if_rdata<=mem_rdata and if_valid=1 on the next cycle.
REQ-031 Completion in DATA (mem_ready=1): ex_rdata<=mem_rdata (loads only) and ex_done=1 on the next cycle.
REQ-032 On completion, strobes SHALL deassert and the state SHALL return to IDLE; there is no back-to-back chaining.
REQ-033 Latency: request seen in IDLE at edge N; strobe asserted from cycle N+1; with mem_ready in cycle N+k, the done/valid pulse occurs in cycle N+k+1.
REQ-034 Minimum latency is 2 cycles.
REQ-035 if_stall (combinational) = if_req & ~if_valid_next, where if_valid_next means FETCH & mem_ready.
REQ-036 ex_stall is defined the same way for ex requests in DATA.
REQ-037 mem_ready SHALL be ignored in IDLE.
REQ-038 If ex_readmem and ex_writemem are both 1, the access SHALL be a store.
REQ-039 A requester dropping its request mid-access SHALL NOT abort the access; the done/valid pulse still occurs.
REQ-040 stall_cycles SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-041 On reset: state=IDLE; mem_read=mem_write=0; mem_addr, mem_wdata, if_rdata, ex_rdata=0; if_valid=ex_done=0; fairness flag=0; stall_cycles=0.
REQ-042 Reset during FETCH/DATA SHALL abandon the access: strobes are 0 the cycle after the reset edge, and no done/valid pulse is produced.

Structure
REQ-043 The state enum, the 32-bit word width and the counter width SHALL live in the shared pipeline package.
REQ-044 The saturating stall counter SHALL be a sub-module named sat_counter.

Verification
REQ-045 Fetch only: if_req=1, if_addr=0x40, mem_ready in 2nd FETCH cycle, mem_rdata=0x2402000A -> mem_read held 2 cycles, if_valid pulse with if_rdata=0x2402000A, if_stall=1 for 2 cycles.
REQ-046 Simultaneous requests in IDLE: if_req and ex_writemem (ex_addr=0x100, ex_wdata=0xDEADBEEF) -> DATA granted first with mem_write=1 and mem_addr=0x100, then FETCH, then a subsequent ex request waits (fairness).
REQ-047 Load: ex_readmem=1, ex_addr=0x200, mem_ready after 5 cycles, mem_rdata=0x12345678 -> ex_done pulse with ex_rdata=0x12345678 and mem_addr stable for all 5 cycles.
REQ-048 Reset asserted in the 2nd DATA cycle -> mem_write=0 next cycle, no ex_done pulse, all outputs at reset values.
REQ-049 Force if_stall=1 for 70000 cycles (mem_ready=0) -> stall_cycles=0xFFFF with no wrap.
REQ-050 ex_readmem=ex_writemem=1 -> only mem_write asserted and ex_rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline definitions for the instruction/data memory port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter
  import mem_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one single-outstanding memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              ex_readmem,
  input  logic              ex_writemem,
  input  logic [WORD_W-1:0] ex_addr,
  input  logic [WORD_W-1:0] ex_wdata,
  output logic [WORD_W-1:0] ex_rdata,
  output logic              ex_done,
  output logic              ex_stall,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  stall_cycles
);

  state_e            state_q, state_d;
  logic              fair_q, fair_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [WORD_W-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_W-1:0] ex_rdata_q, ex_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              ex_done_q, ex_done_d;

  logic ex_req;
  logic fetch_done;
  logic data_done;

  assign ex_req     = ex_readmem | ex_writemem;
  assign fetch_done = (state_q == FETCH) & mem_ready;
  assign data_done  = (state_q == DATA) & mem_ready;

  assign if_stall = if_req & ~fetch_done;
  assign ex_stall = ex_req & ~data_done;

  // Grant / completion logic; mem_* registers only move on a grant or completion edge.
  always_comb begin
    state_d     = state_q;
    fair_d      = fair_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if_rdata_d  = if_rdata_q;
    ex_rdata_d  = ex_rdata_q;
    if_valid_d  = 1'b0;
    ex_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // A fetch that was waiting behind a data completion wins exactly once.
        if (ex_req && !(fair_q && if_req)) begin
          state_d     = DATA;
          fair_d      = 1'b0;
          mem_addr_d  = ex_addr;
          mem_wdata_d = ex_wdata;
          mem_write_d = ex_writemem;
          mem_read_d  = ~ex_writemem;
        end else if (if_req) begin
          state_d     = FETCH;
          fair_d      = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if_valid_d  = 1'b1;
          if_rdata_d  = mem_rdata;
        end
      end
      DATA: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          ex_done_d   = 1'b1;
          fair_d      = if_req;
          if (!mem_write_q) begin
            ex_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      fair_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      if_rdata_q  <= '0;
      ex_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      ex_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fair_q      <= fair_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      if_rdata_q  <= if_rdata_d;
      ex_rdata_q  <= ex_rdata_d;
      if_valid_q  <= if_valid_d;
      ex_done_q   <= ex_done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign if_rdata  = if_rdata_q;
  assign ex_rdata  = ex_rdata_q;
  assign if_valid  = if_valid_q;
  assign ex_done   = ex_done_q;

  sat_counter u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (if_stall),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        ex_readmem;
  logic        ex_writemem;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] ex_rdata;
  logic        ex_done;
  logic        ex_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_valid     (if_valid),
    .if_stall     (if_stall),
    .ex_readmem   (ex_readmem),
    .ex_writemem  (ex_writemem),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rdata     (ex_rdata),
    .ex_done      (ex_done),
    .ex_stall     (ex_stall),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .stall_cycles (stall_cycles)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one access record, pending pulses, and persistent results.
  bit          m_known = 1'b0;
  bit          m_busy, m_fetch, m_store, m_fair;
  logic [31:0] m_addr, m_wdata;
  bit          e_if_valid, e_ex_done;
  logic [31:0] e_if_rdata, e_ex_rdata;
  int          e_cnt;

  function automatic bit model_if_stall();
    return if_req && !(m_busy && m_fetch && mem_ready);
  endfunction

  function automatic bit model_ex_stall();
    return (ex_readmem || ex_writemem) && !(m_busy && !m_fetch && mem_ready);
  endfunction

  always @(posedge clock) begin
    bit stall_now;
    stall_now = model_if_stall();
    if (reset) begin
      m_known    = 1'b1;
      m_busy     = 1'b0;
      m_fetch    = 1'b0;
      m_store    = 1'b0;
      m_fair     = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      e_if_valid = 1'b0;
      e_ex_done  = 1'b0;
      e_if_rdata = '0;
      e_ex_rdata = '0;
      e_cnt      = 0;
    end else begin
      if (stall_now && e_cnt < 65535) e_cnt = e_cnt + 1;
      e_if_valid = 1'b0;
      e_ex_done  = 1'b0;
      if (m_busy) begin
        if (mem_ready) begin
          m_busy = 1'b0;
          if (m_fetch) begin
            e_if_valid = 1'b1;
            e_if_rdata = mem_rdata;
          end else begin
            e_ex_done = 1'b1;
            if (!m_store) e_ex_rdata = mem_rdata;
            m_fair = if_req;
          end
        end
      end else if ((ex_readmem || ex_writemem) && !(m_fair && if_req)) begin
        m_busy  = 1'b1;
        m_fetch = 1'b0;
        m_store = ex_writemem;
        m_addr  = ex_addr;
        m_wdata = ex_wdata;
        m_fair  = 1'b0;
      end else if (if_req) begin
        m_busy  = 1'b1;
        m_fetch = 1'b1;
        m_store = 1'b0;
        m_addr  = if_addr;
        m_fair  = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-low-phase.
  always @(negedge clock) begin
    #2;
    if (m_known) begin
      chk1("mem_read", mem_read, m_busy && (m_fetch || !m_store));
      chk1("mem_write", mem_write, m_busy && !m_fetch && m_store);
      if (m_busy) chk32("mem_addr", mem_addr, m_addr);
      if (m_busy && !m_fetch && m_store) chk32("mem_wdata", mem_wdata, m_wdata);
      chk1("if_valid", if_valid, e_if_valid);
      chk1("ex_done", ex_done, e_ex_done);
      chk32("if_rdata", if_rdata, e_if_rdata);
      chk32("ex_rdata", ex_rdata, e_ex_rdata);
      chk32("stall_cycles", {16'h0, stall_cycles}, 32'(e_cnt));
      chk1("if_stall", if_stall, model_if_stall());
      chk1("ex_stall", ex_stall, model_ex_stall());
    end
  end

  task automatic idle_inputs();
    if_req      = 1'b0;
    ex_readmem  = 1'b0;
    ex_writemem = 1'b0;
    mem_ready   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bit          f_wait;
    bit          e_wait;
    logic [1:0]  op;
    reset     = 1'b1;
    if_addr   = '0;
    ex_addr   = '0;
    ex_wdata  = '0;
    mem_rdata = '0;
    idle_inputs();
    do_reset();

    // Fetch only, ready in the 2nd FETCH cycle.
    if_addr = 32'h40;
    if_req  = 1'b1;
    #3 chk1("f_stall_idle", if_stall, 1'b1);
    @(negedge clock);
    mem_ready = 1'b0;
    #3 chk1("f_read_c1", mem_read, 1'b1);
    chk32("f_addr_c1", mem_addr, 32'h40);
    chk1("f_stall_c1", if_stall, 1'b1);
    @(negedge clock);
    mem_ready = 1'b1;
    mem_rdata = 32'h2402000A;
    #3 chk1("f_read_c2", mem_read, 1'b1);
    chk1("f_stall_c2", if_stall, 1'b0);
    @(negedge clock);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    #3 chk1("f_valid", if_valid, 1'b1);
    chk32("f_rdata", if_rdata, 32'h2402000A);
    chk1("f_read_off", mem_read, 1'b0);
    chk32("f_stall_cnt", {16'h0, stall_cycles}, 32'd2);

    // Simultaneous requests, then fairness.
    @(negedge clock);
    #3 chk1("f_valid_gone", if_valid, 1'b0);
    if_req      = 1'b1;
    if_addr     = 32'h80;
    ex_writemem = 1'b1;
    ex_addr     = 32'h100;
    ex_wdata    = 32'hDEADBEEF;
    @(negedge clock);
    mem_ready = 1'b1;
    mem_rdata = 32'h0;
    #3 chk1("s_write", mem_write, 1'b1);
    chk1("s_no_read", mem_read, 1'b0);
    chk32("s_addr", mem_addr, 32'h100);
    chk32("s_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clock);
    ex_writemem = 1'b0;
    ex_readmem  = 1'b1;
    ex_addr     = 32'h104;
    mem_ready   = 1'b0;
    #3 chk1("s_done", ex_done, 1'b1);
    @(negedge clock);
    mem_ready = 1'b1;
    mem_rdata = 32'h8C010000;
    #3 chk1("s_fair_read", mem_read, 1'b1);
    chk32("s_fair_addr", mem_addr, 32'h80);
    chk1("s_ex_waits", ex_stall, 1'b1);
    @(negedge clock);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    #3 chk1("s_if_valid", if_valid, 1'b1);
    chk32("s_if_rdata", if_rdata, 32'h8C010000);
    @(negedge clock);
    mem_ready = 1'b1;
    mem_rdata = 32'h55;
    #3 chk32("s_load_addr", mem_addr, 32'h104);
    chk1("s_load_read", mem_read, 1'b1);
    @(negedge clock);
    ex_readmem = 1'b0;
    mem_ready  = 1'b0;
    #3 chk1("s_load_done", ex_done, 1'b1);
    chk32("s_load_rdata", ex_rdata, 32'h55);

    // Load with a five-cycle memory wait.
    @(negedge clock);
    ex_readmem = 1'b1;
    ex_addr    = 32'h200;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      mem_ready = (i == 4);
      mem_rdata = (i == 4) ? 32'h12345678 : $urandom;
      #3 chk32("l_addr_hold", mem_addr, 32'h200);
      chk1("l_read_hold", mem_read, 1'b1);
    end
    @(negedge clock);
    ex_readmem = 1'b0;
    mem_ready  = 1'b0;
    #3 chk1("l_done", ex_done, 1'b1);
    chk32("l_rdata", ex_rdata, 32'h12345678);

    // Read and write together behave as a store.
    @(negedge clock);
    ex_readmem  = 1'b1;
    ex_writemem = 1'b1;
    ex_addr     = 32'h400;
    ex_wdata    = 32'hCAFEF00D;
    @(negedge clock);
    mem_ready = 1'b1;
    mem_rdata = 32'hBADBAD00;
    #3 chk1("b_write", mem_write, 1'b1);
    chk1("b_no_read", mem_read, 1'b0);
    chk32("b_wdata", mem_wdata, 32'hCAFEF00D);
    @(negedge clock);
    ex_readmem  = 1'b0;
    ex_writemem = 1'b0;
    mem_ready   = 1'b0;
    #3 chk1("b_done", ex_done, 1'b1);
    chk32("b_rdata_kept", ex_rdata, 32'h12345678);

    // Reset in the 2nd DATA cycle abandons the store.
    @(negedge clock);
    ex_writemem = 1'b1;
    ex_addr     = 32'h300;
    ex_wdata    = 32'h11;
    @(negedge clock);
    mem_ready = 1'b0;
    #3 chk1("r_write_c1", mem_write, 1'b1);
    @(negedge clock);
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clock);
    reset       = 1'b0;
    ex_writemem = 1'b0;
    mem_ready   = 1'b0;
    #3 chk1("r_write_off", mem_write, 1'b0);
    chk1("r_read_off", mem_read, 1'b0);
    chk1("r_no_done", ex_done, 1'b0);
    chk32("r_addr", mem_addr, 32'h0);
    chk32("r_wdata", mem_wdata, 32'h0);
    chk32("r_ex_rdata", ex_rdata, 32'h0);
    chk32("r_if_rdata", if_rdata, 32'h0);
    chk32("r_cnt", {16'h0, stall_cycles}, 32'h0);
    @(negedge clock);
    #3 chk1("r_no_done_late", ex_done, 1'b0);

    // Randomized traffic from two well-behaved requesters.
    f_wait = 1'b0;
    e_wait = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if (f_wait && e_if_valid) f_wait = 1'b0;
      if (!f_wait) begin
        if (!if_req || e_if_valid) begin
          if_req  = ($urandom_range(0, 1) == 1);
          if_addr = $urandom;
        end else if (m_busy && m_fetch && $urandom_range(0, 29) == 0) begin
          if_req = 1'b0;
          f_wait = 1'b1;
        end
      end
      if (e_wait && e_ex_done) e_wait = 1'b0;
      if (!e_wait) begin
        if (!(ex_readmem || ex_writemem) || e_ex_done) begin
          op          = 2'($urandom_range(0, 3));
          ex_readmem  = op[0];
          ex_writemem = op[1];
          ex_addr     = $urandom;
          ex_wdata    = $urandom;
        end else if (m_busy && !m_fetch && $urandom_range(0, 29) == 0) begin
          ex_readmem  = 1'b0;
          ex_writemem = 1'b0;
          e_wait      = 1'b1;
        end
      end
    end

    // Long stall saturates the counter.
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h500;
    repeat (70000) @(negedge clock);
    #3 chk32("sat_cnt", {16'h0, stall_cycles}, 32'h0000FFFF);
    chk1("sat_stall", if_stall, 1'b1);

    do_reset();
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
